// File: rtl/crossing_ctrl.sv
// Pedestrian crossing controller: GREEN/YELLOW/RED/WALK sequencer with
// programmable phase durations, latched walk request and emergency all-stop.
module crossing_ctrl #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk_2,
   input  logic             reset_n,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_sel,
   input  logic [CNT_W-1:0] cfg_val,
   input  logic             ped_req,
   input  logic             emerg,
   output logic [2:0]       light,
   output logic             walk,
   output logic             req_pend,
   output logic [1:0]       phase,
   output logic [CNT_W-1:0] remaining
);

   localparam logic [1:0] ST_GREEN  = 2'd0;
   localparam logic [1:0] ST_YELLOW = 2'd1;
   localparam logic [1:0] ST_RED    = 2'd2;
   localparam logic [1:0] ST_WALK   = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_pend_q, req_pend_d;
   logic [CNT_W-1:0] dur_q [4];
   logic [CNT_W-1:0] dur_d [4];

   logic [CNT_W-1:0] dur_cur_c;
   logic             timeout_c;

   // Exit compare always uses the live duration register of the current phase
   assign dur_cur_c = dur_q[state_q];
   assign timeout_c = (cnt_q >= dur_cur_c);

   // Duration register file write port
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         dur_d[i] = dur_q[i];
      end
      if (cfg_we) begin
         dur_d[cfg_sel] = cfg_val;
      end
   end

   // Next-state, phase counter and pending-request logic
   always_comb begin
      logic advance;
      advance    = 1'b0;
      state_d    = state_q;
      cnt_d      = timeout_c ? dur_cur_c : cnt_q + 1'b1;
      req_pend_d = req_pend_q;

      case (state_q)
         ST_GREEN: begin
            if (timeout_c && req_pend_q) begin
               state_d = ST_YELLOW;
               advance = 1'b1;
            end
         end
         ST_YELLOW: begin
            if (timeout_c) begin
               state_d = ST_RED;
               advance = 1'b1;
            end
         end
         ST_RED: begin
            if (timeout_c) begin
               state_d = req_pend_q ? ST_WALK : ST_GREEN;
               advance = 1'b1;
            end
         end
         default: begin
            if (timeout_c) begin
               state_d = ST_GREEN;
               advance = 1'b1;
            end
         end
      endcase

      if (advance) begin
         cnt_d = '0;
      end

      // Emergency overrides every timed or cfg-induced exit
      if (emerg) begin
         state_d = ST_RED;
         cnt_d   = '0;
      end

      // Requests are ignored while walking; clearing on WALK entry beats a new set
      if (ped_req && (state_q != ST_WALK)) begin
         req_pend_d = 1'b1;
      end
      if ((state_d == ST_WALK) && (state_q != ST_WALK)) begin
         req_pend_d = 1'b0;
      end
   end

   // State registers with asynchronous reset to the power-on configuration
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_GREEN;
         cnt_q      <= '0;
         req_pend_q <= 1'b0;
         dur_q[0]   <= CNT_W'(7);
         dur_q[1]   <= CNT_W'(2);
         dur_q[2]   <= CNT_W'(3);
         dur_q[3]   <= CNT_W'(4);
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_pend_q <= req_pend_d;
         for (int i = 0; i < 4; i++) begin
            dur_q[i] <= dur_d[i];
         end
      end
   end

   // Lamp decode from registered state only
   always_comb begin
      light = 3'b100;
      case (state_q)
         ST_GREEN:  light = 3'b001;
         ST_YELLOW: light = 3'b010;
         default:   light = 3'b100;
      endcase
   end

   assign walk      = (state_q == ST_WALK);
   assign phase     = state_q;
   assign req_pend  = req_pend_q;
   assign remaining = (cnt_q <= dur_cur_c) ? (dur_cur_c - cnt_q) : '0;

endmodule

// File: tb/tb_crossing_ctrl.sv
// Scoreboard bench for crossing_ctrl: directed per-cycle vectors push
// expected outputs; monitors pop and compare after each edge or async event.
module tb_crossing_ctrl;

   logic       clk_2 = 1'b0;
   logic       reset_n = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_sel = 2'd0;
   logic [3:0] cfg_val = 4'd0;
   logic       ped_req = 1'b0;
   logic       emerg = 1'b0;
   logic [2:0] light;
   logic       walk;
   logic       req_pend;
   logic [1:0] phase;
   logic [3:0] remaining;

   typedef struct {
      logic [2:0] light;
      logic       walk;
      logic       rp;
      logic [1:0] ph;
      logic [3:0] rem;
      int         scen;
      int         step;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   scen = 0;
   int   step = 0;
   event async_ev;

   crossing_ctrl #(.CNT_W(4)) dut (
      .clk_2     (clk_2),
      .reset_n   (reset_n),
      .cfg_we    (cfg_we),
      .cfg_sel   (cfg_sel),
      .cfg_val   (cfg_val),
      .ped_req   (ped_req),
      .emerg     (emerg),
      .light     (light),
      .walk      (walk),
      .req_pend  (req_pend),
      .phase     (phase),
      .remaining (remaining)
   );

   always #5 clk_2 = ~clk_2;

   function automatic logic [2:0] lamp(input logic [1:0] ph);
      case (ph)
         2'd0:    lamp = 3'b001;
         2'd1:    lamp = 3'b010;
         default: lamp = 3'b100;
      endcase
   endfunction

   task automatic push(input logic [1:0] ph, input logic [3:0] rem, input logic rp);
      exp_t e;
      e.light = lamp(ph);
      e.walk  = (ph == 2'd3);
      e.rp    = rp;
      e.ph    = ph;
      e.rem   = rem;
      e.scen  = scen;
      e.step  = step;
      step++;
      exp_q.push_back(e);
   endtask

   task automatic check(input exp_t e);
      checks++;
      if (light !== e.light || walk !== e.walk || req_pend !== e.rp ||
          phase !== e.ph || remaining !== e.rem) begin
         failures++;
         $display("FAIL scen%0d step%0d: got light=%b walk=%b req_pend=%b phase=%0d remaining=%0d, want light=%b walk=%b req_pend=%b phase=%0d remaining=%0d",
                  e.scen, e.step, light, walk, req_pend, phase, remaining,
                  e.light, e.walk, e.rp, e.ph, e.rem);
      end
   endtask

   // Edge monitor: compare one expectation after every rising edge
   always @(posedge clk_2) begin
      #1;
      if (exp_q.size() > 0) check(exp_q.pop_front());
   end

   // Async monitor: compare between edges on request
   always @(async_ev) begin
      if (exp_q.size() > 0) check(exp_q.pop_front());
   end

   // One clock cycle of stimulus plus the outputs expected after its edge
   task automatic cyc(input logic ped, input logic em, input logic we,
                      input logic [1:0] sel, input logic [3:0] val,
                      input logic [1:0] ph, input logic [3:0] rem, input logic rp);
      @(negedge clk_2);
      reset_n = 1'b1;
      ped_req = ped;
      emerg   = em;
      cfg_we  = we;
      cfg_sel = sel;
      cfg_val = val;
      push(ph, rem, rp);
   endtask

   task automatic idle(input logic [1:0] ph, input logic [3:0] rem, input logic rp);
      cyc(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, ph, rem, rp);
   endtask

   task automatic run_phase(input logic [1:0] ph, input int d, input logic rp);
      for (int i = 0; i <= d; i++) idle(ph, 4'(d - i), rp);
   endtask

   task automatic do_reset(input int s);
      @(negedge clk_2);
      scen = s;
      step = 0;
      reset_n = 1'b0;
      ped_req = 1'b0;
      emerg = 1'b0;
      cfg_we = 1'b0;
      push(2'd0, 4'd7, 1'b0);
      @(negedge clk_2);
      push(2'd0, 4'd7, 1'b0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

   initial begin
      // Idle GREEN: remaining counts down then holds
      do_reset(1);
      for (int k = 1; k <= 50; k++) idle(2'd0, (k >= 7) ? 4'd0 : 4'(7 - k), 1'b0);

      // Full cycle with walk
      do_reset(2);
      idle(2'd0, 4'd6, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0, 4'd5, 1'b1);
      for (int k = 3; k <= 7; k++) idle(2'd0, 4'(7 - k), 1'b1);
      run_phase(2'd1, 2, 1'b1);
      run_phase(2'd2, 3, 1'b1);
      run_phase(2'd3, 4, 1'b0);
      idle(2'd0, 4'd7, 1'b0);
      idle(2'd0, 4'd6, 1'b0);

      // Emergency during YELLOW, then during WALK
      do_reset(3);
      cyc(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0, 4'd6, 1'b1);
      for (int k = 2; k <= 7; k++) idle(2'd0, 4'(7 - k), 1'b1);
      idle(2'd1, 4'd2, 1'b1);
      repeat (3) cyc(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 2'd2, 4'd3, 1'b1);
      idle(2'd2, 4'd2, 1'b1);
      idle(2'd2, 4'd1, 1'b1);
      idle(2'd2, 4'd0, 1'b1);
      idle(2'd3, 4'd4, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 2'd2, 4'd3, 1'b0);
      idle(2'd2, 4'd2, 1'b0);
      idle(2'd2, 4'd1, 1'b0);
      idle(2'd2, 4'd0, 1'b0);
      idle(2'd0, 4'd7, 1'b0);

      // Shortening GREEN below cnt, cfg write during emergency
      do_reset(4);
      cyc(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0, 4'd6, 1'b1);
      for (int k = 2; k <= 5; k++) idle(2'd0, 4'(7 - k), 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 2'd0, 4'd1, 2'd0, 4'd0, 1'b1);
      run_phase(2'd1, 2, 1'b1);
      run_phase(2'd2, 3, 1'b1);
      run_phase(2'd3, 4, 1'b0);
      idle(2'd0, 4'd1, 1'b0);
      idle(2'd0, 4'd0, 1'b0);
      idle(2'd0, 4'd0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 2'd2, 4'd1, 2'd2, 4'd1, 1'b0);
      idle(2'd2, 4'd0, 1'b0);
      idle(2'd0, 4'd1, 1'b0);
      idle(2'd0, 4'd0, 1'b0);

      // ped_req held through WALK is ignored; clear wins on WALK entry
      do_reset(5);
      cyc(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0, 4'd6, 1'b1);
      for (int k = 2; k <= 7; k++) idle(2'd0, 4'(7 - k), 1'b1);
      run_phase(2'd1, 2, 1'b1);
      run_phase(2'd2, 3, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 2'd3, 4'd4, 1'b0);
      for (int k = 3; k >= 0; k--) cyc(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 2'd3, 4'(k), 1'b0);
      idle(2'd0, 4'd7, 1'b0);
      idle(2'd0, 4'd6, 1'b0);
      idle(2'd0, 4'd5, 1'b0);
      idle(2'd0, 4'd4, 1'b0);

      // Async reset mid-WALK restores outputs and durations
      do_reset(6);
      cyc(1'b1, 1'b0, 1'b1, 2'd0, 4'd3, 2'd0, 4'd2, 1'b1);
      idle(2'd0, 4'd1, 1'b1);
      idle(2'd0, 4'd0, 1'b1);
      run_phase(2'd1, 2, 1'b1);
      run_phase(2'd2, 3, 1'b1);
      idle(2'd3, 4'd4, 1'b0);
      idle(2'd3, 4'd3, 1'b0);
      @(negedge clk_2);
      #2 reset_n = 1'b0;
      #1 push(2'd0, 4'd7, 1'b0);
      -> async_ev;
      idle(2'd0, 4'd6, 1'b0);
      idle(2'd0, 4'd5, 1'b0);

      repeat (3) @(negedge clk_2);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
